// File: rtl/conv1_pkg.sv
// rtl/conv1_pkg.sv - shared constants, state and slice types for the conv1 window scheduler
package conv1_pkg;

    localparam int DEF_IMG_W      = 32;
    localparam int DEF_IMG_H      = 32;
    localparam int DEF_FILT_DIM   = 5;
    localparam int DEF_FILT_INST  = 4;
    localparam int DEF_PXL_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH = 64;

    localparam int OUT_W            = DEF_IMG_W - DEF_FILT_DIM + 1;
    localparam int OUT_H            = DEF_IMG_H - DEF_FILT_DIM + 1;
    localparam int NUM_COL_GRP      = OUT_W / DEF_FILT_INST;
    localparam int SLICES_PER_FRAME = OUT_H * NUM_COL_GRP;

    // Column groups must tile the output width exactly; no right-edge padding exists.
    localparam bit GRP_DIV_OK = (OUT_W % DEF_FILT_INST) == 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_DONE
    } sched_state_e;

    typedef logic [DEF_FILT_DIM*DEF_DATA_WIDTH-1:0] slice_t;

endpackage

// File: rtl/conv1_win_cnt.sv
// rtl/conv1_win_cnt.sv - output row / column-group counters with last-slice flag
module conv1_win_cnt
    import conv1_pkg::*;
#(
    parameter int NUM_ROWS = OUT_H,
    parameter int NUM_GRPS = NUM_COL_GRP,
    localparam int RW = $clog2(NUM_ROWS),
    localparam int GW = $clog2(NUM_GRPS)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [RW-1:0] row_o,
    output logic [GW-1:0] grp_o,
    output logic          last_o
);

    logic [RW-1:0] row_q, row_d;
    logic [GW-1:0] grp_q, grp_d;
    logic          row_last;
    logic          grp_last;

    assign row_last = (row_q == RW'(NUM_ROWS - 1));
    assign grp_last = (grp_q == GW'(NUM_GRPS - 1));

    always_comb begin
        row_d = row_q;
        grp_d = grp_q;
        if (clr_i) begin
            row_d = '0;
            grp_d = '0;
        end else if (adv_i) begin
            if (grp_last) begin
                grp_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                grp_d = grp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_q <= '0;
            grp_q <= '0;
        end else begin
            row_q <= row_d;
            grp_q <= grp_d;
        end
    end

    assign row_o  = row_q;
    assign grp_o  = grp_q;
    assign last_o = row_last && grp_last;

endmodule

// File: rtl/conv1_window_sched.sv
// rtl/conv1_window_sched.sv - walks the 5x5 conv1 window over the frame, one 5x8 slice per step
module conv1_window_sched
    import conv1_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int FILT_DIM   = DEF_FILT_DIM,
    parameter int FILT_INST  = DEF_FILT_INST,
    parameter int PXL_WIDTH  = DEF_PXL_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           win_req_o,
    output logic [4:0]                     win_row_o,
    output logic [4:0]                     win_col_o,
    input  logic                           win_ack_i,
    input  logic [FILT_DIM*DATA_WIDTH-1:0] win_data_i,
    output logic                           out_vld_o,
    input  logic                           out_rdy_i,
    output logic [FILT_DIM*DATA_WIDTH-1:0] out_data_o,
    output logic [4:0]                     out_row_o,
    output logic [4:0]                     out_col_o
);

    localparam int ROWS = IMG_H - FILT_DIM + 1;
    localparam int GRPS = (IMG_W - FILT_DIM + 1) / FILT_INST;
    localparam int RW   = $clog2(ROWS);
    localparam int GW   = $clog2(GRPS);

    if (!GRP_DIV_OK || ((IMG_W - FILT_DIM + 1) % FILT_INST) != 0
        || (DATA_WIDTH % PXL_WIDTH) != 0) begin : g_bad_geometry
        $error("conv1_window_sched: column groups do not tile the output width");
    end

    sched_state_e state_q, state_d;

    logic [FILT_DIM*DATA_WIDTH-1:0] data_q;
    logic [4:0]                     tag_row_q;
    logic [4:0]                     tag_col_q;
    logic                           capture;
    logic                           cnt_adv;
    logic                           cnt_clr;
    logic [RW-1:0]                  cnt_row;
    logic [GW-1:0]                  cnt_grp;
    logic                           cnt_last;
    logic [4:0]                     cur_row;
    logic [4:0]                     cur_col;

    // Counters are cleared both while idle and on abort so a restart always begins at (0,0).
    assign cnt_clr = (state_q == ST_IDLE) || abort_i;

    conv1_win_cnt #(
        .NUM_ROWS (ROWS),
        .NUM_GRPS (GRPS)
    ) u_win_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr),
        .adv_i   (cnt_adv),
        .row_o   (cnt_row),
        .grp_o   (cnt_grp),
        .last_o  (cnt_last)
    );

    assign cur_row = 5'(cnt_row);
    assign cur_col = 5'(cnt_grp * FILT_INST);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        cnt_adv = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (win_ack_i) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (out_rdy_i) begin
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q    <= '0;
            tag_row_q <= '0;
            tag_col_q <= '0;
        end else if (capture) begin
            data_q    <= win_data_i;
            tag_row_q <= cur_row;
            tag_col_q <= cur_col;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign win_req_o  = (state_q == ST_REQ);
    assign out_vld_o  = (state_q == ST_HOLD);
    assign win_row_o  = cur_row;
    assign win_col_o  = cur_col;
    assign out_data_o = data_q;
    assign out_row_o  = tag_row_q;
    assign out_col_o  = tag_col_q;

endmodule
